name_packer: RTL and testbench

NAME_PACKER -- requirements
Module: name_packer

---
 rtl/name_packer.sv | 74 +++++++
 tb/tb_name_packer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/name_packer.sv
// name_packer: packs serial words into ping-pong name slots with overflow truncation (optional trunc counter via NAME_PACKER_TRUNC_CNT_EN)
module name_packer #(
  parameter int WORD_SIZE       = 32,
  parameter int MAX_NAME_LENGTH = 8,
  parameter int LEN_W           = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] word_in,
  input  logic                 word_valid_in,
  input  logic                 word_last_in,
  output logic                 word_ready_out,
  output logic [WORD_SIZE-1:0] name_out [MAX_NAME_LENGTH],
  output logic [LEN_W-1:0]     name_len_out,
  output logic                 name_trunc_out,
  output logic                 name_valid_out,
`ifdef NAME_PACKER_TRUNC_CNT_EN
  output logic [15:0]          trunc_cnt_out,
`endif
  input  logic                 name_ready_in
);
  localparam int IW = MAX_NAME_LENGTH > 1 ? $clog2(MAX_NAME_LENGTH) : 1;
  localparam logic FILL    = 1'b0;
  localparam logic DISCARD = 1'b1;
  logic                 state;
  logic [IW-1:0]        idx;
  logic                 wr, rd;
  logic [1:0]           occ;
  logic [WORD_SIZE-1:0] slot [2][MAX_NAME_LENGTH];
  logic [LEN_W-1:0]     slot_len [2];
  logic                 slot_trunc [2];
  logic                 acc, fill_acc, commit, xfer;
  assign word_ready_out = state == DISCARD || occ != 2'd2;
  assign acc            = word_valid_in && word_ready_out;
  assign fill_acc       = acc && state == FILL;
  assign commit         = fill_acc && (word_last_in || idx == IW'(MAX_NAME_LENGTH - 1));
  assign name_valid_out = occ != 2'd0;
  assign xfer           = name_valid_out && name_ready_in;
  always_comb begin
    for (int i = 0; i < MAX_NAME_LENGTH; i++) name_out[i] = name_valid_out ? slot[rd][i] : '0;
    name_len_out   = name_valid_out ? slot_len[rd] : '0;
    name_trunc_out = name_valid_out && slot_trunc[rd];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      idx   <= '0;
      wr    <= 1'b0;
      rd    <= 1'b0;
      occ   <= '0;
    end else begin
      occ <= occ + {1'b0, commit} - {1'b0, xfer};
      if (xfer) rd <= ~rd;
      if (fill_acc) begin
        if (idx == '0) for (int i = 0; i < MAX_NAME_LENGTH; i++) slot[wr][i] <= '0;
        slot[wr][idx] <= word_in;
        idx <= commit ? '0 : idx + IW'(1);
      end
      if (commit) begin
        slot_len[wr]   <= LEN_W'(idx) + LEN_W'(1);
        slot_trunc[wr] <= !word_last_in;
        wr             <= ~wr;
        if (!word_last_in) state <= DISCARD;
      end
      if (acc && state == DISCARD && word_last_in) state <= FILL;
    end
  end
`ifdef NAME_PACKER_TRUNC_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) trunc_cnt_out <= '0;
    else if (commit && !word_last_in && trunc_cnt_out != 16'hFFFF) trunc_cnt_out <= trunc_cnt_out + 16'd1;
  end
`endif
endmodule

// File: tb/tb_name_packer.sv
// tb_name_packer: randomized and directed checks of name_packer against a queue-based reference model
module tb_name_packer;
  localparam int W = 32;
  localparam int M = 8;
  localparam int L = 4;
  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] word_in;
  logic         word_valid_in, word_last_in, word_ready_out;
  logic [W-1:0] name_out [M];
  logic [L-1:0] name_len_out;
  logic         name_trunc_out, name_valid_out, name_ready_in;
`ifdef NAME_PACKER_TRUNC_CNT_EN
  logic [15:0]  trunc_cnt_out;
`endif
  int           exp_cnt;
  always #5 clk = ~clk;
  name_packer #(.WORD_SIZE(W), .MAX_NAME_LENGTH(M), .LEN_W(L)) dut (
    .clk(clk),
    .rst(rst),
    .word_in(word_in),
    .word_valid_in(word_valid_in),
    .word_last_in(word_last_in),
    .word_ready_out(word_ready_out),
    .name_out(name_out),
    .name_len_out(name_len_out),
    .name_trunc_out(name_trunc_out),
    .name_valid_out(name_valid_out),
`ifdef NAME_PACKER_TRUNC_CNT_EN
    .trunc_cnt_out(trunc_cnt_out),
`endif
    .name_ready_in(name_ready_in)
  );
  typedef struct {
    logic [W-1:0] w [M];
    int           len;
    bit           trunc;
  } name_t;
  name_t        q[$];
  name_t        seen[$];
  logic [W-1:0] cur[$];
  bit           discard;
  int           n_cmp, n_bad;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(bit v, logic [W-1:0] w, bit l, bit nr);
    bit    exp_rdy, acc, xfer;
    name_t n;
    word_valid_in = v;
    word_in       = w;
    word_last_in  = l;
    name_ready_in = nr;
    @(negedge clk);
    exp_rdy = discard || q.size() < 2;
    check("word_ready", word_ready_out, exp_rdy);
    check("name_valid", name_valid_out, q.size() != 0);
    if (q.size() != 0) begin
      check("name_len", name_len_out, q[0].len);
      check("name_trunc", name_trunc_out, q[0].trunc);
      for (int i = 0; i < M; i++) check($sformatf("name_w%0d", i), name_out[i], q[0].w[i]);
    end
`ifdef NAME_PACKER_TRUNC_CNT_EN
    check("trunc_cnt", trunc_cnt_out, exp_cnt);
`endif
    if (name_valid_out && nr) begin
      for (int i = 0; i < M; i++) n.w[i] = name_out[i];
      n.len   = int'(name_len_out);
      n.trunc = name_trunc_out;
      seen.push_back(n);
    end
    acc  = v && exp_rdy;
    xfer = q.size() != 0 && nr;
    @(posedge clk);
    if (xfer) void'(q.pop_front());
    if (acc) begin
      if (discard) begin
        if (l) discard = 1'b0;
      end else begin
        cur.push_back(w);
        if (l || cur.size() == M) begin
          n.len   = cur.size();
          n.trunc = !l;
          for (int i = 0; i < M; i++) n.w[i] = i < cur.size() ? cur[i] : '0;
          q.push_back(n);
          cur.delete();
          discard = !l;
          if (!l && exp_cnt < 16'hFFFF) exp_cnt++;
        end
      end
    end
    #1;
  endtask
  task automatic idle(int n, bit nr);
    repeat (n) cyc(1'b0, '0, 1'b0, nr);
  endtask
  task automatic send(int n, logic [W-1:0] base, bit nr);
    int t;
    bit ok;
    for (int k = 0; k < n; k++) begin
      t = 0;
      do begin
        ok = discard || q.size() < 2;
        cyc(1'b1, base + W'(k), k == n - 1, nr);
        t++;
      end while (!ok && t < 20);
      if (!ok) check("send_timeout", 1, 0);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    word_valid_in = 1'b0;
    word_last_in  = 1'b0;
    word_in       = '0;
    name_ready_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    cur.delete();
    discard = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    check("rst_valid", name_valid_out, 0);
    check("rst_len", name_len_out, 0);
    check("rst_trunc", name_trunc_out, 0);
    check("rst_ready", word_ready_out, 1);
    for (int i = 0; i < M; i++) check($sformatf("rst_w%0d", i), name_out[i], 0);
`ifdef NAME_PACKER_TRUNC_CNT_EN
    check("rst_trunc_cnt", trunc_cnt_out, 0);
`endif
    @(posedge clk);
    #1;
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_cnt = 0;
    do_reset();
    seen.delete();
    send(3, 'hA1, 1'b1);
    idle(3, 1'b1);
    check("basic_count", seen.size(), 1);
    if (seen.size() > 0) begin
      check("basic_len", seen[0].len, 3);
      check("basic_trunc", seen[0].trunc, 0);
      check("basic_w0", seen[0].w[0], 'hA1);
      check("basic_w2", seen[0].w[2], 'hA3);
      check("basic_w3", seen[0].w[3], 0);
    end
    seen.delete();
    send(10, 'h01, 1'b1);
    send(1, 'hFF, 1'b1);
    idle(3, 1'b1);
    check("ovf_count", seen.size(), 2);
    if (seen.size() > 1) begin
      check("ovf_len", seen[0].len, 8);
      check("ovf_trunc", seen[0].trunc, 1);
      check("ovf_w7", seen[0].w[7], 'h08);
      check("ovf_next_len", seen[1].len, 1);
      check("ovf_next_w0", seen[1].w[0], 'hFF);
      check("ovf_next_trunc", seen[1].trunc, 0);
    end
    seen.delete();
    send(2, 'h10, 1'b0);
    send(2, 'h20, 1'b0);
    check("bp_ready_low", word_ready_out, 0);
    idle(3, 1'b0);
    check("bp_hold_w0", name_out[0], 'h10);
    send(2, 'h30, 1'b1);
    idle(4, 1'b1);
    check("bp_count", seen.size(), 3);
    if (seen.size() > 2) begin
      check("bp_first", seen[0].w[0], 'h10);
      check("bp_second", seen[1].w[0], 'h20);
      check("bp_third", seen[2].w[1], 'h31);
    end
    seen.delete();
    send(1, 'h40, 1'b0);
    cyc(1'b1, 'h50, 1'b1, 1'b1);
    check("sim_valid", name_valid_out, 1);
    check("sim_w0", name_out[0], 'h50);
    idle(3, 1'b1);
    check("sim_count", seen.size(), 2);
    if (seen.size() > 1) begin
      check("sim_first", seen[0].w[0], 'h40);
      check("sim_second", seen[1].w[0], 'h50);
    end
    send(1, 'h70, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, W'('h60 + k), 1'b0, 1'b0);
    do_reset();
    seen.delete();
    send(2, 'hB1, 1'b1);
    idle(3, 1'b1);
    check("rstmid_count", seen.size(), 1);
    if (seen.size() > 0) begin
      check("rstmid_len", seen[0].len, 2);
      check("rstmid_w0", seen[0].w[0], 'hB1);
      check("rstmid_w1", seen[0].w[1], 'hB2);
    end
`ifdef NAME_PACKER_TRUNC_CNT_EN
    do_reset();
    for (int k = 0; k < 3; k++) send(9, W'(k * 'h10), 1'b1);
    idle(3, 1'b1);
    check("cnt_three", trunc_cnt_out, 3);
    do_reset();
`endif
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(3) != 0, $urandom, $urandom_range(4) == 0, $urandom_range(9) < 7);
    idle(4, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
